// File: rtl/cpu_pkg.sv
// Shared decode-stage types and MIPS encoding constants for the cpu_id slice.
package cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    alu_op_t alu_op;
    logic    mem_to_reg;
    logic    link;
    logic    shift;
  } id_ctrl_t;

  localparam int unsigned CTRL_W = $bits(id_ctrl_t);

  localparam id_ctrl_t NOP_CTRL = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_src:    1'b0,
    alu_op:     AluAdd,
    mem_to_reg: 1'b0,
    link:       1'b0,
    shift:      1'b0
  };

  typedef enum logic [0:0] {StRun, StHalted} id_state_t;

  // True when the instruction reads rt as a source operand (R-type, branches, stores).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OpRtype) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port, r0 hardwired to zero,
// write-through bypass so a same-cycle write is visible on the read ports.
module regfile
  import cpu_pkg::*;
#(
  parameter int unsigned REG_DEPTH = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) begin
      ra_data = (we && (waddr == ra_addr)) ? wdata : regs[ra_addr];
    end
    if (rb_addr != '0) begin
      rb_data = (we && (waddr == rb_addr)) ? wdata : regs[rb_addr];
    end
  end

endmodule

// File: rtl/cpu_id.sv
// MIPS instruction-decode stage with load-use hazard detection and the ID/EX register.
// Define ID_STALL_STATS_EN to add the saturating stall_count output.
module cpu_id
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned REG_DEPTH = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       if_current_pc,
  input  logic [31:0]       if_ins,
  input  logic [31:0]       if_cycle_count,
  input  logic              if_halt,
  input  logic              ex_flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_reg_addr,
  input  logic [31:0]       wb_reg_data,
  output logic              stall,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_ins,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       id_rs_data,
  output logic [31:0]       id_rt_data,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_dest,
  output logic [31:0]       id_imm,
  output logic [4:0]        id_shamt,
  output logic [31:0]       id_cycle_count,
  output logic              id_halt
`ifdef ID_STALL_STATS_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  id_state_t state_q;
  id_ctrl_t  id_ctrl_q;
  id_ctrl_t  dec_ctrl;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;
  logic [31:0] rs_data, rt_data;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        hazard, load_bubble, go_halt;

  assign op    = if_ins[31:26];
  assign rs    = if_ins[25:21];
  assign rt    = if_ins[20:16];
  assign rd    = if_ins[15:11];
  assign funct = if_ins[5:0];
  assign id_ctrl = id_ctrl_q;

  regfile #(
    .REG_DEPTH (REG_DEPTH)
  ) u_regfile (
    .clk     (clk),
    .clr     (clr),
    .ra_addr (rs),
    .ra_data (rs_data),
    .rb_addr (rt),
    .rb_data (rt_data),
    .we      (wb_reg_write),
    .waddr   (wb_reg_addr),
    .wdata   (wb_reg_data)
  );

  always_comb begin
    dec_ctrl = NOP_CTRL;
    dec_dest = '0;
    dec_imm  = {{16{if_ins[15]}}, if_ins[15:0]};
    case (op)
      OpRtype: begin
        dec_ctrl.reg_write = 1'b1;
        dec_dest = rd;
        case (funct)
          FnSll:          begin dec_ctrl.alu_op = AluSll; dec_ctrl.shift = 1'b1; end
          FnSrl:          begin dec_ctrl.alu_op = AluSrl; dec_ctrl.shift = 1'b1; end
          FnSra:          begin dec_ctrl.alu_op = AluSra; dec_ctrl.shift = 1'b1; end
          FnJr: begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.jump      = 1'b1;
            dec_dest           = '0;
          end
          FnAdd, FnAddu:  dec_ctrl.alu_op = AluAdd;
          FnSub, FnSubu:  dec_ctrl.alu_op = AluSub;
          FnAnd:          dec_ctrl.alu_op = AluAnd;
          FnOr:           dec_ctrl.alu_op = AluOr;
          FnXor:          dec_ctrl.alu_op = AluXor;
          FnNor:          dec_ctrl.alu_op = AluNor;
          FnSlt:          dec_ctrl.alu_op = AluSlt;
          FnSltu:         dec_ctrl.alu_op = AluSltu;
          default: begin
            dec_ctrl = NOP_CTRL;
            dec_dest = '0;
          end
        endcase
      end
      OpJ:  dec_ctrl.jump = 1'b1;
      OpJal: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.link      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_dest           = 5'd31;
      end
      OpBeq, OpBne: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = AluSub;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_dest           = rt;
        case (op)
          OpSlti:  dec_ctrl.alu_op = AluSlt;
          OpSltiu: dec_ctrl.alu_op = AluSltu;
          OpAndi:  begin dec_ctrl.alu_op = AluAnd; dec_imm = {16'h0, if_ins[15:0]}; end
          OpOri:   begin dec_ctrl.alu_op = AluOr;  dec_imm = {16'h0, if_ins[15:0]}; end
          OpXori:  begin dec_ctrl.alu_op = AluXor; dec_imm = {16'h0, if_ins[15:0]}; end
          OpLui:   begin dec_ctrl.alu_op = AluLui; dec_imm = {if_ins[15:0], 16'h0}; end
          default: dec_ctrl.alu_op = AluAdd;
        endcase
      end
      OpLw: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_dest            = rt;
      end
      OpSw: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      default: begin
        dec_ctrl = NOP_CTRL;
        dec_dest = '0;
      end
    endcase
    // Writes to r0 are discarded, so never advertise r0 as a live destination.
    if (dec_dest == '0) begin
      dec_ctrl.reg_write = 1'b0;
    end
  end

  assign hazard = id_ctrl_q.mem_read && (id_dest != '0) &&
                  ((id_dest == rs) || ((id_dest == rt) && uses_rt(op)));
  assign stall       = !clr && (state_q == StRun) && !ex_flush && hazard;
  assign load_bubble = (state_q == StHalted) || ex_flush || hazard || if_halt;
  assign go_halt     = (state_q == StRun) && if_halt && !ex_flush && !hazard;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= StRun;
      id_pc          <= RESET_PC;
      id_ins         <= '0;
      id_ctrl_q      <= NOP_CTRL;
      id_rs_data     <= '0;
      id_rt_data     <= '0;
      id_rs          <= '0;
      id_rt          <= '0;
      id_dest        <= '0;
      id_imm         <= '0;
      id_shamt       <= '0;
      id_cycle_count <= '0;
      id_halt        <= 1'b0;
    end else begin
      if (load_bubble) begin
        id_pc      <= RESET_PC;
        id_ins     <= '0;
        id_ctrl_q  <= NOP_CTRL;
        id_rs_data <= '0;
        id_rt_data <= '0;
        id_rs      <= '0;
        id_rt      <= '0;
        id_dest    <= '0;
        id_imm     <= '0;
        id_shamt   <= '0;
      end else begin
        id_pc      <= if_current_pc;
        id_ins     <= if_ins;
        id_ctrl_q  <= dec_ctrl;
        id_rs_data <= rs_data;
        id_rt_data <= rt_data;
        id_rs      <= rs;
        id_rt      <= rt;
        id_dest    <= dec_dest;
        id_imm     <= dec_imm;
        id_shamt   <= if_ins[10:6];
      end
      if (state_q == StRun) begin
        id_cycle_count <= if_cycle_count;
      end
      if (go_halt) begin
        state_q <= StHalted;
        id_halt <= 1'b1;
      end
    end
  end

`ifdef ID_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
